bullet_pool: RTL and testbench
==============================

# bullet_pool

Parametrised player-bullet manager replacing the single-bullet sprite path. Holds up to N_BULLETS independent bullets: spawns them at the ship on a fire request, advances them upward once per frame, retires them off-screen or on collision, and renders the bullet layer for the VGA pixel stream. Sits between the player/input logic and the pixel mixer; `valid`/`rgb` feed the priority mux like the other sprite layers.

## Interface
- N_BULLETS, 8: pool size, 1..16
- BULLET_W, 2: bullet width in pixels
- BULLET_H, 8: bullet height in pixels
- SPEED, 4: upward pixels per frame tick
- SPAWN_DX, 7: x offset from ship_x to the bullet's left edge
- COOLDOWN, 8: frame ticks of refire lockout
- COLOR, 3'b111: bullet colour
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (vblank start)
- fire  in  1  level, sampled only on frame_tick
- ship_x, ship_y  in  10 each  ship top-left position
- hit_clear  in  N_BULLETS  one-hot-or-more; kills the flagged bullets
- x, y  in  10 each  current pixel coordinate
- active  out  N_BULLETS  per-slot live flags
- bx_flat, by_flat  out  10*N_BULLETS each  slot i at bits [10i+9:10i], for the collision block
- fire_ack  out  1  one-cycle pulse: a bullet was spawned
- pool_full  out  1  all slots active
- rgb  out  3  pixel colour, 0 when not valid
- valid  out  1  pixel lies inside a live bullet

## Operation
- Per slot: active bit, 10-bit bx, 10-bit by. Cooldown counter `cd`, 5 bits minimum.
- hit_clear: any cycle, clears `active[i]` for each set bit at the next edge; overrides a same-cycle move or spawn into that slot.
- On frame_tick, in one edge:
  - Move: for each active slot not hit, if by < SPEED then deactivate, else by <= by - SPEED. Comparison is done before subtraction, so no wrap occurs.
  - Spawn: if fire=1, cd==0, ship_y >= BULLET_H, and a free slot exists, take the lowest-index slot that was free *before* this tick. Set bx = ship_x + SPAWN_DX and by = ship_y - BULLET_H, load cd = COOLDOWN, and pulse fire_ack next cycle.
  - Slots freed by this tick's move or hit are not reusable until the following tick.
  - If no spawn occurs and cd != 0, then cd <= cd - 1. A refused fire (full pool, cooldown, ship too high) is dropped, not queued.
- Render: in_i = active[i] && x >= bx_i && x < bx_i + BULLET_W && y >= by_i && y < by_i + BULLET_H. Sums use 11-bit arithmetic to avoid wrap at the 1023 edge. valid = OR of in_i. rgb = valid ? COLOR : 0. Both are registered.
- pool_full = &active, combinational from the registers.

## Timing
- Reset: active=0, all bx/by=0, cd=0, fire_ack=0, rgb=0, valid=0. Reset asserted during a frame_tick wins; no spawn or move happens.
- Render latency is exactly 1 clk from x/y to rgb/valid. The mixer delays the other layers by 1 to match.
- State updates are visible on active/bx/by one clk after frame_tick or hit_clear.
- With COOLDOWN=C, the minimum spacing between spawns is C+1 frame ticks.
- With held fire and a free pool, the first spawn happens on the first frame_tick after release of reset.

## Configuration
- BULLET_COOLDOWN_EN defined: cooldown counter and gating active as above.
- Not defined: no `cd` register; spawn is allowed on every frame_tick when fire=1 and a slot is free. COOLDOWN is ignored.

## Test plan
- Reset, fire=1, ship=(100,200), one tick: slot0 at (107,192), fire_ack pulses once, active=8'b00000001.
- Hold fire, 20 ticks, COOLDOWN=8: spawns on ticks 1, 10, 19 only. Each prior bullet by drops by 4 per tick.
- Bullet at by=3, tick: slot deactivates. Same-tick fire with a full pool gets no spawn; the next tick spawns into that slot.
- Fill all 8 slots (cooldown disabled): pool_full=1, fire ignored. hit_clear=8'b00100000 frees slot5, and the next fire fills slot5.
- hit_clear on slot0 coincident with frame_tick: slot0 inactive, by unchanged, no respawn that tick.
- Bullet at (50,60): pixels (50,60) and (51,67) give valid=1, rgb=111 one clk later. Pixels (52,60) and (50,68) give valid=0, rgb=000.

Source files
------------

// File: rtl/bullet_pool.sv
// -----------------------------------------------------------------------------
// bullet_pool
//
// Player-bullet manager. Keeps up to N_BULLETS independent bullets. On a frame
// tick it spawns a bullet at the ship when fire is held, advances every live
// bullet upward by SPEED pixels, and retires bullets that leave the top of the
// screen. hit_clear can kill any bullet on any cycle. The module also renders
// the bullet layer for the VGA pixel stream, with a one-clock latency.
//
// Optional feature macro: BULLET_COOLDOWN_EN
//   defined   : a refire cooldown counter gates spawning for COOLDOWN ticks
//   undefined : a spawn is allowed on every frame tick; COOLDOWN is ignored
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   frame_tick  in   one-cycle pulse per frame (vblank start)
//   fire        in   fire request level, sampled only on frame_tick
//   ship_x/y    in   ship top-left position (10 bits each)
//   hit_clear   in   per-slot kill flags from the collision block
//   x, y        in   current pixel coordinate (10 bits each)
//   active      out  per-slot live flags
//   bx_flat     out  slot i left edge at bits [10i+9:10i]
//   by_flat     out  slot i top edge at bits [10i+9:10i]
//   fire_ack    out  one-cycle pulse after a bullet was spawned
//   pool_full   out  every slot is live
//   rgb         out  pixel colour, 0 when not valid (registered)
//   valid       out  pixel lies inside a live bullet (registered)
// -----------------------------------------------------------------------------
module bullet_pool #(
  parameter int         N_BULLETS = 8,
  parameter int         BULLET_W  = 2,
  parameter int         BULLET_H  = 8,
  parameter int         SPEED     = 4,
  parameter int         SPAWN_DX  = 7,
  parameter int         COOLDOWN  = 8,
  parameter logic [2:0] COLOR     = 3'b111
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     fire,
  input  logic [9:0]               ship_x,
  input  logic [9:0]               ship_y,
  input  logic [N_BULLETS-1:0]     hit_clear,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  output logic [N_BULLETS-1:0]     active,
  output logic [10*N_BULLETS-1:0]  bx_flat,
  output logic [10*N_BULLETS-1:0]  by_flat,
  output logic                     fire_ack,
  output logic                     pool_full,
  output logic [2:0]               rgb,
  output logic                     valid
);

  localparam int IDX_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

  // Advance one bullet upward. Bit 10 says whether it survives; the test is
  // made before the subtraction so the position never wraps past zero.
  function automatic logic [10:0] move_up(input logic [9:0] by_cur);
    if (by_cur < 10'(SPEED))
      return {1'b0, by_cur};
    else
      return {1'b1, by_cur - 10'(SPEED)};
  endfunction

  // Pixel-in-box test. Right/bottom bounds use 11 bits so a bullet touching
  // column/row 1023 does not wrap its far edge to zero.
  function automatic logic pix_inside(input logic [9:0] px, input logic [9:0] py,
                                      input logic [9:0] ox, input logic [9:0] oy);
    logic [10:0] x_end;
    logic [10:0] y_end;
    x_end = {1'b0, ox} + 11'(BULLET_W);
    y_end = {1'b0, oy} + 11'(BULLET_H);
    return (px >= ox) && ({1'b0, px} < x_end) &&
           (py >= oy) && ({1'b0, py} < y_end);
  endfunction

  logic [9:0]           bx_r  [N_BULLETS];
  logic [9:0]           by_r  [N_BULLETS];
  logic [9:0]           bx_nx [N_BULLETS];
  logic [9:0]           by_nx [N_BULLETS];
  logic [N_BULLETS-1:0] active_nx;
  logic                 ack_nx;
  logic [10:0]          mv;

  logic [IDX_W-1:0]     free_idx;
  logic                 free_found;
  logic                 cd_ok;
  logic                 spawn_ok;

  logic [N_BULLETS-1:0] in_hit_p0;
  logic                 vld_p0;

`ifdef BULLET_COOLDOWN_EN
  localparam int CD_W = ($clog2(COOLDOWN + 1) > 5) ? $clog2(COOLDOWN + 1) : 5;
  logic [CD_W-1:0] cd;
  logic [CD_W-1:0] cd_nx;

  assign cd_ok = (cd == '0);

  always_comb begin
    cd_nx = cd;
    if (spawn_ok)
      cd_nx = CD_W'(COOLDOWN);
    else if (frame_tick && (cd != '0))
      cd_nx = cd - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cd <= '0;
    else
      cd <= cd_nx;
  end
`else
  assign cd_ok = 1'b1;
`endif

  // Lowest-index slot that is free before this tick. Slots freed by this
  // tick's move or hit are deliberately not visible here.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  // A spawn into a slot that is being hit on the same cycle is cancelled
  // outright (no ack, no cooldown load) since the hit wins that slot.
  assign spawn_ok = frame_tick && fire && cd_ok &&
                    (ship_y >= 10'(BULLET_H)) &&
                    free_found && !hit_clear[free_idx];

  always_comb begin
    active_nx = active;
    ack_nx    = spawn_ok;
    mv        = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      bx_nx[i] = bx_r[i];
      by_nx[i] = by_r[i];
    end

    if (frame_tick) begin
      for (int i = 0; i < N_BULLETS; i++) begin
        if (active[i] && !hit_clear[i]) begin
          mv = move_up(by_r[i]);
          active_nx[i] = mv[10];
          by_nx[i]     = mv[9:0];
        end
      end
    end

    if (spawn_ok) begin
      active_nx[free_idx] = 1'b1;
      bx_nx[free_idx]     = ship_x + 10'(SPAWN_DX);
      by_nx[free_idx]     = ship_y - 10'(BULLET_H);
    end

    active_nx = active_nx & ~hit_clear;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= '0;
      fire_ack <= 1'b0;
      for (int i = 0; i < N_BULLETS; i++) begin
        bx_r[i] <= '0;
        by_r[i] <= '0;
      end
    end else begin
      active   <= active_nx;
      fire_ack <= ack_nx;
      for (int i = 0; i < N_BULLETS; i++) begin
        bx_r[i] <= bx_nx[i];
        by_r[i] <= by_nx[i];
      end
    end
  end

  for (genvar g = 0; g < N_BULLETS; g++) begin : g_flat
    assign bx_flat[10*g +: 10] = bx_r[g];
    assign by_flat[10*g +: 10] = by_r[g];
  end

  assign pool_full = &active;

  // Stage p0: per-slot pixel compare on the live registers
  always_comb begin
    in_hit_p0 = '0;
    for (int i = 0; i < N_BULLETS; i++)
      in_hit_p0[i] = active[i] && pix_inside(x, y, bx_r[i], by_r[i]);
  end

  assign vld_p0 = |in_hit_p0;

  // Stage p0 -> p1: registered layer output, one clock after x/y
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      rgb   <= 3'b000;
    end else begin
      valid <= vld_p0;
      rgb   <= vld_p0 ? COLOR : 3'b000;
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
module tb_bullet_pool;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        fire;
  logic [9:0]  ship_x;
  logic [9:0]  ship_y;
  logic [7:0]  hit_clear;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [7:0]  active;
  logic [79:0] bx_flat;
  logic [79:0] by_flat;
  logic        fire_ack;
  logic        pool_full;
  logic [2:0]  rgb;
  logic        valid;

  int total;
  int bad;

  bullet_pool dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .fire       (fire),
    .ship_x     (ship_x),
    .ship_y     (ship_y),
    .hit_clear  (hit_clear),
    .x          (x),
    .y          (y),
    .active     (active),
    .bx_flat    (bx_flat),
    .by_flat    (by_flat),
    .fire_ack   (fire_ack),
    .pool_full  (pool_full),
    .rgb        (rgb),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] bx_of(input int i);
    return bx_flat[10*i +: 10];
  endfunction

  function automatic logic [9:0] by_of(input int i);
    return by_flat[10*i +: 10];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_tick = 1'b0; fire = 1'b0; hit_clear = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic tick(input logic f, input logic [9:0] sx, input logic [9:0] sy,
                      input logic [7:0] hc);
    frame_tick = 1'b1; fire = f; ship_x = sx; ship_y = sy; hit_clear = hc;
    step();
    frame_tick = 1'b0; fire = 1'b0; hit_clear = '0;
  endtask

  task automatic test_reset();
    do_reset();
    tick(1'b1, 10'd100, 10'd200, 8'h00);
    reset = 1'b1; frame_tick = 1'b1; fire = 1'b1;
    step();
    total++; if (active !== 8'h00) begin bad++; $display("FAIL reset_active got=%h want=%h", active, 8'h00); end
    total++; if (by_flat !== 80'd0) begin bad++; $display("FAIL reset_by got=%h want=0", by_flat); end
    total++; if (bx_flat !== 80'd0) begin bad++; $display("FAIL reset_bx got=%h want=0", bx_flat); end
    total++; if (fire_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", fire_ack); end
    total++; if (valid !== 1'b0 || rgb !== 3'b000) begin bad++; $display("FAIL reset_pix got=%b/%b want=0/000", valid, rgb); end
    total++; if (pool_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", pool_full); end
    reset = 1'b0; frame_tick = 1'b0; fire = 1'b0;
  endtask

  task automatic test_spawn();
    do_reset();
    tick(1'b1, 10'd100, 10'd200, 8'h00);
    total++; if (active !== 8'h01) begin bad++; $display("FAIL spawn_active got=%h want=%h", active, 8'h01); end
    total++; if (bx_of(0) !== 10'd107) begin bad++; $display("FAIL spawn_bx got=%0d want=107", bx_of(0)); end
    total++; if (by_of(0) !== 10'd192) begin bad++; $display("FAIL spawn_by got=%0d want=192", by_of(0)); end
    total++; if (fire_ack !== 1'b1) begin bad++; $display("FAIL spawn_ack got=%b want=1", fire_ack); end
    step();
    total++; if (fire_ack !== 1'b0) begin bad++; $display("FAIL spawn_ack_pulse got=%b want=0", fire_ack); end
    total++; if (by_of(0) !== 10'd192) begin bad++; $display("FAIL spawn_by_hold got=%0d want=192", by_of(0)); end
  endtask

  task automatic test_ship_high();
    do_reset();
    tick(1'b1, 10'd100, 10'd7, 8'h00);
    total++; if (active !== 8'h00) begin bad++; $display("FAIL high_active got=%h want=00", active); end
    total++; if (fire_ack !== 1'b0) begin bad++; $display("FAIL high_ack got=%b want=0", fire_ack); end
    tick(1'b1, 10'd100, 10'd8, 8'h00);
    total++; if (active !== 8'h01) begin bad++; $display("FAIL edge_active got=%h want=01", active); end
    total++; if (by_of(0) !== 10'd0) begin bad++; $display("FAIL edge_by got=%0d want=0", by_of(0)); end
  endtask

  task automatic test_hold_fire();
    logic [19:0] acks;
    logic [19:0] want;
    logic [9:0]  want_by1;
    do_reset();
    acks = '0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 10'd100, 10'd200, 8'h00);
      acks[k] = fire_ack;
    end
`ifdef BULLET_COOLDOWN_EN
    want     = 20'b0100_0000_0010_0000_0001;
    want_by1 = 10'd152;
`else
    want     = 20'h000FF;
    want_by1 = 10'd120;
`endif
    total++; if (acks !== want) begin bad++; $display("FAIL hold_acks got=%b want=%b", acks, want); end
    total++; if (by_of(0) !== 10'd116) begin bad++; $display("FAIL hold_by0 got=%0d want=116", by_of(0)); end
    total++; if (by_of(1) !== want_by1) begin bad++; $display("FAIL hold_by1 got=%0d want=%0d", by_of(1), want_by1); end
  endtask

`ifndef BULLET_COOLDOWN_EN
  task automatic test_retire_full();
    do_reset();
    tick(1'b1, 10'd100, 10'd39, 8'h00);
    for (int k = 0; k < 7; k++) tick(1'b1, 10'd100, 10'd200, 8'h00);
    total++; if (active !== 8'hFF) begin bad++; $display("FAIL fill_active got=%h want=FF", active); end
    total++; if (pool_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", pool_full); end
    total++; if (by_of(0) !== 10'd3) begin bad++; $display("FAIL fill_by0 got=%0d want=3", by_of(0)); end
    tick(1'b1, 10'd100, 10'd200, 8'h00);
    total++; if (active !== 8'hFE) begin bad++; $display("FAIL retire_active got=%h want=FE", active); end
    total++; if (fire_ack !== 1'b0) begin bad++; $display("FAIL retire_ack got=%b want=0", fire_ack); end
    total++; if (pool_full !== 1'b0) begin bad++; $display("FAIL retire_full got=%b want=0", pool_full); end
    tick(1'b1, 10'd100, 10'd200, 8'h00);
    total++; if (active !== 8'hFF) begin bad++; $display("FAIL reuse_active got=%h want=FF", active); end
    total++; if (fire_ack !== 1'b1) begin bad++; $display("FAIL reuse_ack got=%b want=1", fire_ack); end
    total++; if (by_of(0) !== 10'd192) begin bad++; $display("FAIL reuse_by0 got=%0d want=192", by_of(0)); end
  endtask

  task automatic test_hit_full();
    tick(1'b1, 10'd100, 10'd200, 8'h00);
    total++; if (fire_ack !== 1'b0) begin bad++; $display("FAIL full_ack got=%b want=0", fire_ack); end
    total++; if (active !== 8'hFF) begin bad++; $display("FAIL full_active got=%h want=FF", active); end
    hit_clear = 8'h20;
    step();
    hit_clear = 8'h00;
    total++; if (active !== 8'hDF) begin bad++; $display("FAIL hit5_active got=%h want=DF", active); end
    total++; if (pool_full !== 1'b0) begin bad++; $display("FAIL hit5_full got=%b want=0", pool_full); end
    total++; if (by_of(0) !== 10'd188) begin bad++; $display("FAIL hit5_by0 got=%0d want=188", by_of(0)); end
    tick(1'b1, 10'd100, 10'd200, 8'h00);
    total++; if (active !== 8'hFF) begin bad++; $display("FAIL refill_active got=%h want=FF", active); end
    total++; if (fire_ack !== 1'b1) begin bad++; $display("FAIL refill_ack got=%b want=1", fire_ack); end
    total++; if (by_of(5) !== 10'd192 || bx_of(5) !== 10'd107) begin bad++; $display("FAIL refill_pos got=%0d,%0d want=107,192", bx_of(5), by_of(5)); end
  endtask
`endif

  task automatic test_hit_tick();
    logic [7:0] want_act;
    logic       want_ack;
    do_reset();
    tick(1'b1, 10'd100, 10'd200, 8'h00);
    tick(1'b1, 10'd100, 10'd200, 8'h01);
`ifdef BULLET_COOLDOWN_EN
    want_act = 8'h00; want_ack = 1'b0;
`else
    want_act = 8'h02; want_ack = 1'b1;
`endif
    total++; if (active !== want_act) begin bad++; $display("FAIL hittick_active got=%h want=%h", active, want_act); end
    total++; if (by_of(0) !== 10'd192) begin bad++; $display("FAIL hittick_by0 got=%0d want=192", by_of(0)); end
    total++; if (fire_ack !== want_ack) begin bad++; $display("FAIL hittick_ack got=%b want=%b", fire_ack, want_ack); end
  endtask

  task automatic test_render();
    do_reset();
    tick(1'b1, 10'd43, 10'd68, 8'h00);
    x = 10'd52; y = 10'd60; step();
    total++; if (valid !== 1'b0 || rgb !== 3'b000) begin bad++; $display("FAIL pix_52_60 got=%b/%b want=0/000", valid, rgb); end
    x = 10'd50; y = 10'd60; #2;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL pix_latency got=%b want=0", valid); end
    step();
    total++; if (valid !== 1'b1 || rgb !== 3'b111) begin bad++; $display("FAIL pix_50_60 got=%b/%b want=1/111", valid, rgb); end
    x = 10'd51; y = 10'd67; step();
    total++; if (valid !== 1'b1 || rgb !== 3'b111) begin bad++; $display("FAIL pix_51_67 got=%b/%b want=1/111", valid, rgb); end
    x = 10'd50; y = 10'd68; step();
    total++; if (valid !== 1'b0 || rgb !== 3'b000) begin bad++; $display("FAIL pix_50_68 got=%b/%b want=0/000", valid, rgb); end
    x = 10'd49; y = 10'd60; step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL pix_49_60 got=%b want=0", valid); end
    x = 10'd50; y = 10'd59; step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL pix_50_59 got=%b want=0", valid); end

    do_reset();
    tick(1'b1, 10'd1015, 10'd208, 8'h00);
    x = 10'd1023; y = 10'd200; step();
    total++; if (valid !== 1'b1 || rgb !== 3'b111) begin bad++; $display("FAIL pix_1023_200 got=%b/%b want=1/111", valid, rgb); end
    x = 10'd1022; y = 10'd207; step();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL pix_1022_207 got=%b want=1", valid); end
    x = 10'd1021; y = 10'd200; step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL pix_1021_200 got=%b want=0", valid); end
    x = 10'd0; y = 10'd200; step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL pix_0_200 got=%b want=0", valid); end
    x = 10'd0; y = 10'd0;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; frame_tick = 1'b0; fire = 1'b0;
    ship_x = '0; ship_y = '0; hit_clear = '0; x = '0; y = '0;
    test_reset();
    test_spawn();
    test_ship_high();
    test_hold_fire();
`ifndef BULLET_COOLDOWN_EN
    test_retire_full();
    test_hit_full();
`endif
    test_hit_tick();
    test_render();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
